fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

F-stage sequencer that owns the fetch PC register and drives the instruction-memory request. It fetches at the current PC and presents the instruction to the F/D pipeline register. When the pipeline advances, it loads the next PC supplied by the combinational next-PC logic. It decouples variable-latency instruction memory from the hazard unit's stall so that exactly one instruction is delivered per advance. It sits between the F/D register, the hazard unit and the next-PC block.

## Interface
- No parameters; constants come from `Defines.v`.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- npc_in  input  32  next PC from the next-PC block; only sampled on an advance.
- stall  input  1  hazard-unit stall; while high, F and D must not advance.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address; always equals f_pc.
- imem_ack  input  1  read data valid this cycle; only meaningful while imem_req=1.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- f_pc  output  32  PC of the instruction currently in F.
- f_instr  output  32  instruction presented to the F/D register.
- f_valid  output  1  f_instr/f_pc are valid this cycle.
- f_exc  output  1  the F instruction is a fetch exception (misaligned or out of range).

## Operation
- States:
  - FETCH: request outstanding or about to issue.
  - READY: instruction buffered, waiting for the stall to drop.
- Registers: pc (32), ibuf (32), excbuf (1), state.
- bad_pc = (pc[1:0] != 0) || pc < `IM_BASE || pc > `IM_LIMIT`.
- imem_req = (state == FETCH) && !bad_pc. imem_addr = pc.
- f_valid:
  - FETCH: f_valid = imem_ack || bad_pc.
  - READY: f_valid = 1.
- f_instr / f_exc:
  - FETCH: f_instr = bad_pc ? 0 : imem_rdata; f_exc = bad_pc.
  - READY: f_instr = ibuf; f_exc = excbuf.
- advance = f_valid && !stall.
- Transitions:
  - FETCH with advance: pc <= npc_in; stay in FETCH. This is back-to-back fetch.
  - FETCH with f_valid && stall: ibuf <= f_instr; excbuf <= f_exc; go to READY; pc is held.
  - FETCH with !f_valid: hold everything; imem_req stays high.
  - READY with !stall: pc <= npc_in; go to FETCH.
  - READY with stall: hold.
- Exception fetches never touch imem. They produce a single nop (0) with f_exc=1 and advance like a normal fetch.
- No flush input: delay-slot semantics mean the instruction after a branch is always delivered.

## Timing
- Reset values: pc = `PC_RESET` (0x0000_3000), state = FETCH, ibuf = 0, excbuf = 0.
- Outputs in the cycle after reset: imem_req=1, imem_addr=0x3000, f_pc=0x3000, f_valid=0, f_instr=0, f_exc=0.
- imem_ack asserted in the same cycle as imem_req is legal (zero-wait). The zero-wait path is combinational: imem_ack -> f_valid -> F/D enable.
- Latency is ack-to-f_valid = 0 cycles. Sustained throughput is 1 instruction per cycle with zero-wait memory and no stall.
- An N-wait memory gives 1 instruction per N+1 cycles.
- imem_req, once high, stays high with a stable address until ack. Stall never withdraws a request.
- Stall arriving in the same cycle as ack: the instruction is buffered, is not lost, and is not refetched.
- Stall dropping in READY: the buffered instruction is consumed that cycle, and the next request issues in the following cycle.
- Reset mid-transaction: any in-flight access is abandoned, and an ack during the reset cycle is ignored. imem shares the same reset and must not return stale acks afterwards.
- pc wrap: npc_in is used unmodified; 32-bit overflow is not checked.

## Structure
- `Defines.v` gains `PC_RESET`, `IM_BASE`, `IM_LIMIT`, `FC_FETCH`, `FC_READY`.
- Single flat module with no sub-modules. The next-PC block stays a sibling instance in the F-stage top. That top wires f_pc to its F_PC input and its NPC output to npc_in.

## Test plan
- Reset, zero-wait memory, npc_in = f_pc+4, no stall:
  - imem_addr reads 0x3000, 0x3004, 0x3008 on consecutive cycles.
  - f_valid is 1 every cycle after the first.
- 2-wait memory:
  - imem_req stays high with addr 0x3000 for 3 cycles.
  - f_valid pulses only in the third cycle, then addr becomes 0x3004.
- Ack for 0x3004 with stall=1 held 3 cycles:
  - state goes to READY; f_instr = buffered word and f_pc = 0x3004 are stable.
  - imem_req=0 for those 3 cycles; the next cycle issues 0x3008.
- npc_in = 0x0000_3402 (misaligned):
  - no imem_req is issued.
  - f_valid=1, f_exc=1, f_instr=0, f_pc=0x3402.
- Reset asserted while a request for 0x3010 waits with ack asserted in the same cycle:
  - the ack is ignored; the next cycle shows f_pc=0x3000, imem_req=1, f_valid=0 only if no ack.
- Jump via npc_in=0x0000_3100 on an advance: the next imem_addr is exactly 0x3100.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - fetch-stage constants, state encoding and PC range helper
package fetch_ctrl_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IM_LIMIT = 32'h0000_6FFC;

    typedef enum logic {
        FC_FETCH = 1'b0,
        FC_READY = 1'b1
    } fc_state_e;

    // A PC outside instruction memory or not word aligned is fetched as an exception nop.
    function automatic logic pc_is_bad(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction-memory request/ack bus between fetch_ctrl and imem
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - F-stage sequencer: owns the fetch PC, issues imem requests and
// buffers one instruction while the hazard unit stalls.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  npc_in,
    input  logic         stall,
    fetch_ctrl_if.master imem,
    output logic [31:0]  f_pc,
    output logic [31:0]  f_instr,
    output logic         f_valid,
    output logic         f_exc
);

    fc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ibuf_q, ibuf_d;
    logic        excbuf_q, excbuf_d;
    logic        bad_pc;
    logic        advance;

    assign bad_pc  = pc_is_bad(pc_q);
    assign advance = f_valid && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FC_FETCH;
            pc_q     <= PC_RESET;
            ibuf_q   <= 32'h0;
            excbuf_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ibuf_q   <= ibuf_d;
            excbuf_q <= excbuf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ibuf_d   = ibuf_q;
        excbuf_d = excbuf_q;
        unique case (state_q)
            FC_FETCH: begin
                if (advance) begin
                    pc_d = npc_in;
                end else if (f_valid) begin
                    // Stalled on the delivery cycle: capture so the word is never refetched.
                    ibuf_d   = f_instr;
                    excbuf_d = f_exc;
                    state_d  = FC_READY;
                end
            end
            FC_READY: begin
                if (!stall) begin
                    pc_d    = npc_in;
                    state_d = FC_FETCH;
                end
            end
            default: state_d = FC_FETCH;
        endcase
    end

    always_comb begin
        imem.imem_req  = (state_q == FC_FETCH) && !bad_pc;
        imem.imem_addr = pc_q;
        f_pc           = pc_q;
        if (state_q == FC_READY) begin
            f_valid = 1'b1;
            f_instr = ibuf_q;
            f_exc   = excbuf_q;
        end else begin
            // Zero-wait path: ack flows straight through to the F/D enable.
            f_valid = imem.imem_ack || bad_pc;
            f_instr = bad_pc ? 32'h0 : imem.imem_rdata;
            f_exc   = bad_pc;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed vector table plus randomized run against a reference model
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc_in;
    logic        stall;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_valid;
    logic        f_exc;

    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .npc_in  (npc_in),
        .stall   (stall),
        .imem    (bus),
        .f_pc    (f_pc),
        .f_instr (f_instr),
        .f_valid (f_valid),
        .f_exc   (f_exc)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] npc;
        logic        stall;
        logic        ack;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic        exc;
    } vec_t;

    vec_t vecs[$];
    vec_t held[$];

    function automatic vec_t mk(input logic [31:0] npc, input logic st, input logic ack,
                                input logic [31:0] rdata, input logic req, input logic [31:0] addr,
                                input logic valid, input logic [31:0] instr, input logic exc);
        vec_t v;
        v.npc = npc; v.stall = st; v.ack = ack; v.rdata = rdata;
        v.req = req; v.addr = addr; v.valid = valid; v.instr = instr; v.exc = exc;
        return v;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    function automatic logic model_bad(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
    endfunction

    initial begin
        logic [31:0] m_pc;
        logic        bad, e_req, e_valid, e_exc;
        logic [31:0] e_instr;
        vec_t        hv;
        int          r;

        // Rows run back to back from reset; the comment on each group gives the PC it starts at.
        // 0x3000: zero-wait, first cycle has no ack
        vecs.push_back(mk(32'h3004, 0, 0, 32'h0,        1, 32'h3000, 0, 32'h0,        0));
        vecs.push_back(mk(32'h3004, 0, 1, 32'h1111_1111, 1, 32'h3000, 1, 32'h1111_1111, 0));
        vecs.push_back(mk(32'h3008, 0, 1, 32'h2222_2222, 1, 32'h3004, 1, 32'h2222_2222, 0));
        vecs.push_back(mk(32'h300C, 0, 1, 32'h3333_3333, 1, 32'h3008, 1, 32'h3333_3333, 0));
        // 0x300C: 2-wait memory
        vecs.push_back(mk(32'h3010, 0, 0, 32'h0,        1, 32'h300C, 0, 32'h0,        0));
        vecs.push_back(mk(32'h3010, 0, 0, 32'h0,        1, 32'h300C, 0, 32'h0,        0));
        vecs.push_back(mk(32'h3010, 0, 1, 32'h4444_4444, 1, 32'h300C, 1, 32'h4444_4444, 0));
        // 0x3010: stall arrives with ack, held, then dropped
        vecs.push_back(mk(32'h3014, 1, 1, 32'h5555_5555, 1, 32'h3010, 1, 32'h5555_5555, 0));
        vecs.push_back(mk(32'h3014, 1, 0, 32'h0,        0, 32'h3010, 1, 32'h5555_5555, 0));
        vecs.push_back(mk(32'h3014, 1, 0, 32'h0,        0, 32'h3010, 1, 32'h5555_5555, 0));
        vecs.push_back(mk(32'h3014, 0, 0, 32'h0,        0, 32'h3010, 1, 32'h5555_5555, 0));
        // 0x3014: jump to 0x3100
        vecs.push_back(mk(32'h3100, 0, 1, 32'h6666_6666, 1, 32'h3014, 1, 32'h6666_6666, 0));
        vecs.push_back(mk(32'h3104, 0, 1, 32'h7777_7777, 1, 32'h3100, 1, 32'h7777_7777, 0));
        vecs.push_back(mk(32'h3402, 0, 1, 32'h8888_8888, 1, 32'h3104, 1, 32'h8888_8888, 0));
        // 0x3402 misaligned: exception nop, stalled twice then consumed
        vecs.push_back(mk(32'h3408, 1, 0, 32'h0,        0, 32'h3402, 1, 32'h0,        1));
        vecs.push_back(mk(32'h3408, 1, 0, 32'h0,        0, 32'h3402, 1, 32'h0,        1));
        vecs.push_back(mk(32'h2FFC, 0, 0, 32'h0,        0, 32'h3402, 1, 32'h0,        1));
        // below base, above limit, then the last legal word
        vecs.push_back(mk(32'h7000, 0, 0, 32'h0,        0, 32'h2FFC, 1, 32'h0,        1));
        vecs.push_back(mk(32'h6FFC, 0, 0, 32'h0,        0, 32'h7000, 1, 32'h0,        1));
        vecs.push_back(mk(32'h3010, 0, 0, 32'h0,        1, 32'h6FFC, 0, 32'h0,        0));
        vecs.push_back(mk(32'h3010, 0, 1, 32'h9999_9999, 1, 32'h6FFC, 1, 32'h9999_9999, 0));
        // 0x3010 waiting; reset follows
        vecs.push_back(mk(32'h3014, 0, 0, 32'h0,        1, 32'h3010, 0, 32'h0,        0));

        reset = 1'b1; npc_in = 32'h0; stall = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            #1;
            reset = 1'b0;
            npc_in = vecs[i].npc; stall = vecs[i].stall;
            bus.imem_ack = vecs[i].ack; bus.imem_rdata = vecs[i].rdata;
            #3;
            chk1 ($sformatf("row%0d req", i),   bus.imem_req, vecs[i].req);
            chk32($sformatf("row%0d addr", i),  bus.imem_addr, vecs[i].addr);
            chk32($sformatf("row%0d f_pc", i),  f_pc, vecs[i].addr);
            chk1 ($sformatf("row%0d valid", i), f_valid, vecs[i].valid);
            chk32($sformatf("row%0d instr", i), f_instr, vecs[i].instr);
            chk1 ($sformatf("row%0d exc", i),   f_exc, vecs[i].exc);
            @(posedge clk);
        end

        // Reset while 0x3010 is waiting and its ack lands in the reset cycle
        #1;
        reset = 1'b1; bus.imem_ack = 1'b1; bus.imem_rdata = 32'hAAAA_AAAA;
        @(posedge clk);
        #1;
        reset = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; npc_in = 32'h3004;
        #3;
        chk32("rst f_pc",  f_pc, 32'h3000);
        chk32("rst addr",  bus.imem_addr, 32'h3000);
        chk1 ("rst req",   bus.imem_req, 1'b1);
        chk1 ("rst valid", f_valid, 1'b0);
        chk1 ("rst exc",   f_exc, 1'b0);

        // Randomized run; the DUT sits at 0x3000 with nothing delivered yet
        m_pc = 32'h3000;
        held.delete();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            bad   = model_bad(m_pc);
            e_req = (held.size() == 0) && !bad;
            stall = ($urandom_range(0, 3) == 0);
            bus.imem_ack   = e_req && ($urandom_range(0, 2) != 0);
            bus.imem_rdata = $urandom;
            r = $urandom_range(0, 99);
            if (r < 70)      npc_in = m_pc + 32'd4;
            else if (r < 85) npc_in = 32'h3000 + (32'($urandom_range(0, 32'h3FFF)) & ~32'd3);
            else begin
                case ($urandom_range(0, 3))
                    0:       npc_in = m_pc + 32'd2;
                    1:       npc_in = 32'h2FFC;
                    2:       npc_in = 32'h7000;
                    default: npc_in = $urandom;
                endcase
            end
            if (held.size() != 0) begin
                e_valid = 1'b1; e_instr = held[0].instr; e_exc = held[0].exc;
            end else begin
                e_valid = bad || bus.imem_ack;
                e_instr = bad ? 32'h0 : bus.imem_rdata;
                e_exc   = bad;
            end
            #3;
            chk1 ("rnd req",   bus.imem_req, e_req);
            chk32("rnd addr",  bus.imem_addr, m_pc);
            chk32("rnd f_pc",  f_pc, m_pc);
            chk1 ("rnd valid", f_valid, e_valid);
            if (e_valid) begin
                chk32("rnd instr", f_instr, e_instr);
                chk1 ("rnd exc",   f_exc, e_exc);
            end
            if (e_valid && !stall) begin
                m_pc = npc_in;
                held.delete();
            end else if (e_valid && held.size() == 0) begin
                hv = mk(32'h0, 0, 0, 32'h0, 0, 32'h0, 1, e_instr, e_exc);
                held.push_back(hv);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
